eviction_controller: RTL and testbench

EVICTION_CONTROLLER -- requirements
Module: eviction_controller

---
 rtl/cache_pkg.sv | 18 +
 rtl/eviction_controller_if.sv | 51 +++++
 rtl/onehot_priority_enc.sv | 31 +++
 rtl/eviction_controller.sv | 188 ++++++++++++++++++
 tb/tb_eviction_controller.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared types and default sizing for the cache eviction controller.
// Holds the controller FSM state encoding and the default set geometry.
package cache_pkg;

    localparam int unsigned DEFAULT_NUM_WAYS   = 512;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        WB_REQ,
        WB_WAIT,
        FILL_REQ,
        FILL_WAIT,
        COMPLETE
    } evict_state_e;

endpackage

// File: rtl/eviction_controller_if.sv
// Bundle of miss, victim-selection, memory and tag-update signals around the eviction controller.
// The master modport is the controller; the slave modport is the cache/memory environment.
interface eviction_controller_if #(
    parameter int unsigned NUM_WAYS   = cache_pkg::DEFAULT_NUM_WAYS,
    parameter int unsigned ADDR_WIDTH = cache_pkg::DEFAULT_ADDR_WIDTH
);

    localparam int unsigned IDX_W = $clog2(NUM_WAYS);

    logic                  miss_valid;
    logic                  miss_ready;
    logic [ADDR_WIDTH-1:0] miss_addr;

    logic                  evict_ready;
    logic [NUM_WAYS-1:0]   evict_target;
    logic [NUM_WAYS-1:0]   way_valid;
    logic [NUM_WAYS-1:0]   way_dirty;
    logic [IDX_W-1:0]      victim_idx;
    logic [ADDR_WIDTH-1:0] victim_addr;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_write;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_resp_valid;

    logic [NUM_WAYS-1:0]   invalidate_way;
    logic [NUM_WAYS-1:0]   fill_way;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic                  done;
    logic                  error;

    modport master (
        input  miss_valid, miss_addr,
        input  evict_ready, evict_target, way_valid, way_dirty, victim_addr,
        input  mem_req_ready, mem_resp_valid,
        output miss_ready, victim_idx,
        output mem_req_valid, mem_req_write, mem_req_addr,
        output invalidate_way, fill_way, fill_addr, done, error
    );

    modport slave (
        output miss_valid, miss_addr,
        output evict_ready, evict_target, way_valid, way_dirty, victim_addr,
        output mem_req_ready, mem_resp_valid,
        input  miss_ready, victim_idx,
        input  mem_req_valid, mem_req_write, mem_req_addr,
        input  invalidate_way, fill_way, fill_addr, done, error
    );

endinterface

// File: rtl/onehot_priority_enc.sv
// Lowest-set-bit encoder: returns the binary index and isolated one-hot of the
// lowest set bit of vec_i, plus a flag telling whether any bit was set.
module onehot_priority_enc #(
    parameter int unsigned WIDTH = 512
) (
    input  logic [WIDTH-1:0]         vec_i,
    output logic [$clog2(WIDTH)-1:0] idx_o,
    output logic [WIDTH-1:0]         onehot_o,
    output logic                     found_o
);

    localparam int unsigned IDX_W = $clog2(WIDTH);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
        idx_o    = '0;
        found_o  = 1'b0;
        onehot_o = '0;
        // Scanning downward lets the last hit, the lowest index, win.
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
        if (found_o) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/eviction_controller.sv
// Cache miss eviction controller: picks a victim way, writes it back if dirty, fetches the
// missing line and pulses the tag update. Optional watchdog: define EVICT_TIMEOUT_EN.
module eviction_controller
    import cache_pkg::*;
#(
    parameter int unsigned NUM_WAYS       = DEFAULT_NUM_WAYS,
    parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input logic                   clk,
    input logic                   reset_n,
    eviction_controller_if.master bus
);

    localparam int unsigned IDX_W = $clog2(NUM_WAYS);

    evict_state_e          state_q;
    logic [ADDR_WIDTH-1:0] miss_addr_q;
    logic [IDX_W-1:0]      victim_idx_q;
    logic [NUM_WAYS-1:0]   victim_oh_q;
    logic                  miss_ready_q;
    logic                  mem_req_valid_q;
    logic                  mem_req_write_q;
    logic [ADDR_WIDTH-1:0] mem_req_addr_q;
    logic [NUM_WAYS-1:0]   invalidate_q;
    logic [NUM_WAYS-1:0]   fill_q;
    logic [ADDR_WIDTH-1:0] fill_addr_q;
    logic                  done_q;

    logic [IDX_W-1:0]      free_idx, evict_idx, victim_idx_d;
    logic [NUM_WAYS-1:0]   free_oh, evict_oh, victim_oh_d;
    logic                  free_found, evict_found;
    logic                  select_go, victim_dirty_d;
    logic                  wait_expired;

    onehot_priority_enc #(.WIDTH(NUM_WAYS)) u_free_enc (
        .vec_i    (~bus.way_valid),
        .idx_o    (free_idx),
        .onehot_o (free_oh),
        .found_o  (free_found)
    );

    onehot_priority_enc #(.WIDTH(NUM_WAYS)) u_evict_enc (
        .vec_i    (bus.evict_target),
        .idx_o    (evict_idx),
        .onehot_o (evict_oh),
        .found_o  (evict_found)
    );

    // An invalid way always beats the policy's choice and never needs a writeback.
    assign victim_idx_d   = free_found ? free_idx : evict_idx;
    assign victim_oh_d    = free_found ? free_oh  : evict_oh;
    assign select_go      = free_found || (bus.evict_ready && evict_found);
    assign victim_dirty_d = !free_found && bus.way_dirty[evict_idx];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            miss_addr_q     <= '0;
            victim_idx_q    <= '0;
            victim_oh_q     <= '0;
            miss_ready_q    <= 1'b1;
            mem_req_valid_q <= 1'b0;
            mem_req_write_q <= 1'b0;
            mem_req_addr_q  <= '0;
            invalidate_q    <= '0;
            fill_q          <= '0;
            fill_addr_q     <= '0;
            done_q          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the pulse defaults below are overridden
            // later in the same block, so each pulse lasts exactly one cycle.
            invalidate_q <= '0;
            fill_q       <= '0;
            fill_addr_q  <= '0;
            done_q       <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (bus.miss_valid) begin
                        miss_addr_q  <= bus.miss_addr;
                        miss_ready_q <= 1'b0;
                        state_q      <= SELECT;
                    end
                end
                SELECT: begin
                    if (select_go) begin
                        victim_idx_q    <= victim_idx_d;
                        victim_oh_q     <= victim_oh_d;
                        mem_req_valid_q <= 1'b1;
                        if (victim_dirty_d) begin
                            mem_req_write_q <= 1'b1;
                            mem_req_addr_q  <= bus.victim_addr;
                            state_q         <= WB_REQ;
                        end else begin
                            mem_req_write_q <= 1'b0;
                            mem_req_addr_q  <= miss_addr_q;
                            invalidate_q    <= free_found ? '0 : victim_oh_d;
                            state_q         <= FILL_REQ;
                        end
                    end
                end
                WB_REQ, FILL_REQ: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        mem_req_write_q <= 1'b0;
                        mem_req_addr_q  <= '0;
                        state_q         <= (state_q == WB_REQ) ? WB_WAIT : FILL_WAIT;
                    end
                end
                WB_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        invalidate_q    <= victim_oh_q;
                        mem_req_valid_q <= 1'b1;
                        mem_req_write_q <= 1'b0;
                        mem_req_addr_q  <= miss_addr_q;
                        state_q         <= FILL_REQ;
                    end else if (wait_expired) begin
                        miss_ready_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                FILL_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        fill_q      <= victim_oh_q;
                        fill_addr_q <= miss_addr_q;
                        done_q      <= 1'b1;
                        state_q     <= COMPLETE;
                    end else if (wait_expired) begin
                        miss_ready_q <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                COMPLETE: begin
                    miss_ready_q <= 1'b1;
                    state_q      <= IDLE;
                end
                default: begin
                    miss_ready_q <= 1'b1;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

`ifdef EVICT_TIMEOUT_EN
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] timer_q;
    logic               error_q;
    logic               waiting;

    assign waiting      = ((state_q == WB_WAIT) || (state_q == FILL_WAIT)) && !bus.mem_resp_valid;
    assign wait_expired = (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

    // timer_q counts completed wait cycles and is zero on every entry to a wait state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer_q <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= waiting && wait_expired;
            if (waiting && !wait_expired) begin
                timer_q <= timer_q + TIMER_W'(1);
            end else begin
                timer_q <= '0;
            end
        end
    end

    assign bus.error = error_q;
`else
    assign wait_expired = 1'b0;
    assign bus.error    = 1'b0;
`endif

    // The tag array answers victim_addr for the way being chosen, so expose it live in SELECT.
    assign bus.victim_idx     = (state_q == SELECT) ? victim_idx_d : victim_idx_q;
    assign bus.miss_ready     = miss_ready_q;
    assign bus.mem_req_valid  = mem_req_valid_q;
    assign bus.mem_req_write  = mem_req_write_q;
    assign bus.mem_req_addr   = mem_req_addr_q;
    assign bus.invalidate_way = invalidate_q;
    assign bus.fill_way       = fill_q;
    assign bus.fill_addr      = fill_addr_q;
    assign bus.done           = done_q;

endmodule

// File: tb/tb_eviction_controller.sv
// Directed bench for eviction_controller: free-way fill, clean and dirty eviction, policy stall,
// request stability under backpressure, reset mid-transaction, and the watchdog when enabled.
`timescale 1ns/1ps
module tb_eviction_controller;
    import cache_pkg::*;

    localparam int unsigned NW = DEFAULT_NUM_WAYS;
    localparam int unsigned AW = DEFAULT_ADDR_WIDTH;
`ifdef EVICT_TIMEOUT_EN
    localparam int unsigned TO = 8;
`else
    localparam int unsigned TO = 256;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    eviction_controller_if #(.NUM_WAYS(NW), .ADDR_WIDTH(AW)) bus ();

    eviction_controller #(
        .NUM_WAYS       (NW),
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NW-1:0] obs, input logic [NW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NW-1:0] bit_at(input int k);
        logic [NW-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    initial begin
        bus.miss_valid     = 1'b0;
        bus.miss_addr      = '0;
        bus.evict_ready    = 1'b0;
        bus.evict_target   = '0;
        bus.way_valid      = '1;
        bus.way_dirty      = '0;
        bus.victim_addr    = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;

        // Reset state
        step();
        step();
        check("rst_miss_ready", bus.miss_ready, 1'b1);
        check("rst_req_valid", bus.mem_req_valid, 1'b0);
        check("rst_req_addr", bus.mem_req_addr, '0);
        check("rst_done", bus.done, 1'b0);
        check("rst_error", bus.error, 1'b0);
        check("rst_fill", bus.fill_way, '0);
        check("rst_inval", bus.invalidate_way, '0);
        check("rst_victim_idx", bus.victim_idx, '0);
        reset_n = 1'b1;
        step();

        // Way 3 invalid: fill without invalidate, done on the 4th edge after acceptance
        bus.way_valid  = ~bit_at(3);
        bus.miss_valid = 1'b1;
        bus.miss_addr  = 32'h100;
        step();
        check("t1_miss_ready_low", bus.miss_ready, 1'b0);
        check("t1_victim_idx", bus.victim_idx, 3);
        bus.miss_valid    = 1'b0;
        bus.mem_req_ready = 1'b1;
        step();
        check("t1_req_valid", bus.mem_req_valid, 1'b1);
        check("t1_req_write", bus.mem_req_write, 1'b0);
        check("t1_req_addr", bus.mem_req_addr, 32'h100);
        check("t1_no_inval", bus.invalidate_way, '0);
        step();
        check("t1_req_dropped", bus.mem_req_valid, 1'b0);
        check("t1_done_early", bus.done, 1'b0);
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        step();
        check("t1_done", bus.done, 1'b1);
        check("t1_fill_way", bus.fill_way, bit_at(3));
        check("t1_fill_addr", bus.fill_addr, 32'h100);
        check("t1_no_inval_end", bus.invalidate_way, '0);
        bus.mem_resp_valid = 1'b0;
        step();
        check("t1_done_pulse", bus.done, 1'b0);
        check("t1_fill_pulse", bus.fill_way, '0);
        check("t1_idle_ready", bus.miss_ready, 1'b1);

        // All valid, clean policy victim 7: invalidate then read only
        bus.way_valid    = '1;
        bus.evict_ready  = 1'b1;
        bus.evict_target = bit_at(7);
        bus.victim_addr  = 32'h700;
        bus.miss_valid   = 1'b1;
        bus.miss_addr    = 32'h200;
        step();
        check("t2_victim_idx", bus.victim_idx, 7);
        bus.miss_valid = 1'b0;
        step();
        check("t2_inval", bus.invalidate_way, bit_at(7));
        check("t2_req", {bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr}, {1'b1, 1'b0, 32'h200});
        bus.mem_req_ready = 1'b1;
        step();
        check("t2_inval_pulse", bus.invalidate_way, '0);
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        step();
        check("t2_done", bus.done, 1'b1);
        check("t2_fill_way", bus.fill_way, bit_at(7));
        check("t2_no_writeback", bus.mem_req_valid, 1'b0);
        bus.mem_resp_valid = 1'b0;
        step();

        // Dirty victim 5: writeback held under backpressure, stray response ignored
        bus.evict_target = bit_at(5);
        bus.way_dirty    = bit_at(5);
        bus.victim_addr  = 32'hAA0;
        bus.miss_valid   = 1'b1;
        bus.miss_addr    = 32'h300;
        step();
        bus.miss_valid = 1'b0;
        step();
        check("t3_wb_req", {bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr}, {1'b1, 1'b1, 32'hAA0});
        check("t3_no_inval_yet", bus.invalidate_way, '0);
        bus.victim_addr    = 32'hBEE;
        bus.mem_resp_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("t3_stall_%0d", i), {bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr},
                  {1'b1, 1'b1, 32'hAA0});
        end
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_ready  = 1'b1;
        step();
        check("t3_wb_accepted", bus.mem_req_valid, 1'b0);
        check("t3_wb_wait_no_inval", bus.invalidate_way, '0);
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        step();
        check("t3_inval", bus.invalidate_way, bit_at(5));
        check("t3_fill_req", {bus.mem_req_valid, bus.mem_req_write, bus.mem_req_addr}, {1'b1, 1'b0, 32'h300});
        bus.mem_resp_valid = 1'b0;
        bus.mem_req_ready  = 1'b1;
        step();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        step();
        check("t3_done", bus.done, 1'b1);
        check("t3_fill_way", bus.fill_way, bit_at(5));
        check("t3_fill_addr", bus.fill_addr, 32'h300);
        bus.mem_resp_valid = 1'b0;
        step();
        check("t3_idle_ready", bus.miss_ready, 1'b1);

        // Empty policy target stalls in SELECT; then bits 2 and 9 pick way 2
        bus.way_dirty    = '0;
        bus.evict_target = '0;
        bus.miss_valid   = 1'b1;
        bus.miss_addr    = 32'h400;
        step();
        bus.miss_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t4_stall_req_%0d", i), bus.mem_req_valid, 1'b0);
            check($sformatf("t4_stall_ready_%0d", i), bus.miss_ready, 1'b0);
        end
        bus.evict_target = bit_at(2) | bit_at(9);
        #1;
        check("t4_victim_idx", bus.victim_idx, 2);
        step();
        check("t4_inval", bus.invalidate_way, bit_at(2));
        check("t4_req_addr", bus.mem_req_addr, 32'h400);
        bus.mem_req_ready = 1'b1;
        step();
        // Reset while in FILL_WAIT, with a response present at the same edge
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        reset_n            = 1'b0;
        step();
        check("t4_rst_done", bus.done, 1'b0);
        check("t4_rst_fill", bus.fill_way, '0);
        check("t4_rst_inval", bus.invalidate_way, '0);
        check("t4_rst_ready", bus.miss_ready, 1'b1);
        check("t4_rst_victim", bus.victim_idx, '0);
        reset_n            = 1'b1;
        bus.mem_resp_valid = 1'b0;
        bus.evict_ready    = 1'b0;
        bus.evict_target   = '0;
        step();
        check("t4_post_rst_done", bus.done, 1'b0);

        // Fill with no response: watchdog fires, or the wait persists indefinitely
        bus.way_valid     = ~bit_at(0);
        bus.miss_valid    = 1'b1;
        bus.miss_addr     = 32'h500;
        bus.mem_req_ready = 1'b1;
        step();
        bus.miss_valid = 1'b0;
        step();
        step();
        check("t5_in_wait", bus.mem_req_valid, 1'b0);
        bus.mem_req_ready = 1'b0;
`ifdef EVICT_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            step();
            check($sformatf("t5_no_err_%0d", i), bus.error, 1'b0);
        end
        step();
        check("t5_error", bus.error, 1'b1);
        check("t5_err_no_done", bus.done, 1'b0);
        check("t5_err_no_fill", bus.fill_way, '0);
        check("t5_err_idle", bus.miss_ready, 1'b1);
        step();
        check("t5_error_pulse", bus.error, 1'b0);
`else
        for (int i = 0; i < 20; i++) begin
            step();
        end
        check("t5_still_waiting", bus.miss_ready, 1'b0);
        check("t5_no_error", bus.error, 1'b0);
        bus.mem_resp_valid = 1'b1;
        step();
        check("t5_late_done", bus.done, 1'b1);
        check("t5_late_fill", bus.fill_way, bit_at(0));
        bus.mem_resp_valid = 1'b0;
        step();
        check("t5_idle_ready", bus.miss_ready, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
